// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared unit ids and default functional-unit latencies.
package issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MEM  = 2'd1,
        UNIT_MULT = 2'd2,
        UNIT_DIV  = 2'd3
    } unit_e;

    localparam int DEF_LAT_INT  = 1;
    localparam int DEF_LAT_MEM  = 2;
    localparam int DEF_LAT_MULT = 4;
    localparam int DEF_LAT_DIV  = 6;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/issue_scheduler_rr_arbiter4.sv
// rr_arbiter4: four-way round-robin pick starting at i_ptr, one-hot grant.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_gnt_vld
);

    logic [1:0] w_idx;

    // Walk from farthest to nearest offset so the request closest to i_ptr wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_gnt     = 4'b0001 << w_idx;
                o_gnt_id  = w_idx;
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: grants one reservation station per cycle, booking the CDB slot its result will use.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int LAT_INT  = DEF_LAT_INT,
    parameter int LAT_MEM  = DEF_LAT_MEM,
    parameter int LAT_MULT = DEF_LAT_MULT,
    parameter int LAT_DIV  = DEF_LAT_DIV
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       flush,
    input  logic       rdy_int,
    input  logic       rdy_mem,
    input  logic       rdy_mult,
    input  logic       rdy_div,
    output logic       issue_int,
    output logic       issue_mem,
    output logic       issue_mult,
    output logic       issue_div,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_sel
);

    localparam int MAX_LAT = max4(LAT_INT, LAT_MEM, LAT_MULT, LAT_DIV);
    localparam int DW      = $clog2(LAT_DIV + 1);

    logic [MAX_LAT:0] r_res;
    logic [MAX_LAT:0] w_res_nxt;
    logic [1:0]       r_owner   [MAX_LAT:0];
    logic [1:0]       w_own_nxt [MAX_LAT:0];
    logic [DW-1:0]    r_div_cnt;
    logic [1:0]       r_ptr;
    logic [3:0]       w_req;
    logic [3:0]       w_gnt;
    logic [1:0]       w_gnt_id;
    logic             w_gnt_vld;
    logic             w_ok;
    int               w_lat;

    assign w_ok  = i_rst_n & ~flush;
    assign w_req = {rdy_div  & ~r_res[LAT_DIV] & (r_div_cnt == '0),
                    rdy_mult & ~r_res[LAT_MULT],
                    rdy_mem  & ~r_res[LAT_MEM],
                    rdy_int  & ~r_res[LAT_INT]} & {4{w_ok}};

    rr_arbiter4 u_arb (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_vld (w_gnt_vld)
    );

    assign {issue_div, issue_mult, issue_mem, issue_int} = w_gnt;
    assign o_cdb_valid = r_res[0];
    assign o_cdb_sel   = r_owner[0];

    assign w_lat = (w_gnt_id == UNIT_INT)  ? LAT_INT  :
                   (w_gnt_id == UNIT_MEM)  ? LAT_MEM  :
                   (w_gnt_id == UNIT_MULT) ? LAT_MULT : LAT_DIV;

    // Booking and shift fused: slot k next cycle is slot k+1 now plus a fresh grant at k+1.
    always_comb begin
        w_res_nxt          = '0;
        w_own_nxt[MAX_LAT] = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            w_res_nxt[k] = r_res[k+1] | (w_gnt_vld && w_lat == k + 1);
            w_own_nxt[k] = (w_gnt_vld && w_lat == k + 1) ? w_gnt_id : r_owner[k+1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            r_res     <= '0;
            r_div_cnt <= '0;
            for (int k = 0; k <= MAX_LAT; k++) r_owner[k] <= '0;
        end else begin
            r_res     <= w_res_nxt;
            r_div_cnt <= w_gnt[UNIT_DIV] ? DW'(LAT_DIV - 1) :
                         (r_div_cnt != '0) ? r_div_cnt - DW'(1) : r_div_cnt;
            for (int k = 0; k <= MAX_LAT; k++) r_owner[k] <= w_own_nxt[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_ptr <= '0;
        else if (w_gnt_vld) r_ptr <= w_gnt_id + 2'd1;
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed checks of grant order, CDB timing, divider lockout, flush and reset.
module tb_issue_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       rdy_int = 1'b0, rdy_mem = 1'b0, rdy_mult = 1'b0, rdy_div = 1'b0;
    logic       issue_int, issue_mem, issue_mult, issue_div;
    logic       o_cdb_valid;
    logic [1:0] o_cdb_sel;
    logic [3:0] iss;
    int         n_pass = 0;
    int         n_total = 0;

    issue_scheduler dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .flush       (flush),
        .rdy_int     (rdy_int),
        .rdy_mem     (rdy_mem),
        .rdy_mult    (rdy_mult),
        .rdy_div     (rdy_div),
        .issue_int   (issue_int),
        .issue_mem   (issue_mem),
        .issue_mult  (issue_mult),
        .issue_div   (issue_div),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_sel   (o_cdb_sel)
    );

    always #5 i_clk = ~i_clk;
    assign iss = {issue_div, issue_mult, issue_mem, issue_int};

    task automatic next_cycle;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_rdy(input logic [3:0] v);
        {rdy_div, rdy_mult, rdy_mem, rdy_int} = v;
    endtask

    task automatic do_reset;
        i_rst_n = 1'b0;
        flush = 1'b0;
        set_rdy(4'b0000);
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        set_rdy(4'b1111);
        #1;
        n_total++;
        if (iss !== 4'b0000) $display("FAIL reset_issue: got %b want 0000", iss);
        else n_pass++;
        next_cycle();
        n_total++;
        if (o_cdb_valid !== 1'b0 || o_cdb_sel !== 2'd0)
            $display("FAIL reset_cdb: got v=%b s=%0d want v=0 s=0", o_cdb_valid, o_cdb_sel);
        else n_pass++;
        set_rdy(4'b0000);
        i_rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_int;
        do_reset();
        rdy_int = 1'b1;
        #1;
        n_total++;
        if (iss !== 4'b0001) $display("FAIL single_issue: got %b want 0001", iss);
        else n_pass++;
        next_cycle();
        rdy_int = 1'b0;
        #1;
        n_total++;
        if (o_cdb_valid !== 1'b1 || o_cdb_sel !== 2'd0)
            $display("FAIL single_cdb: got v=%b s=%0d want v=1 s=0", o_cdb_valid, o_cdb_sel);
        else n_pass++;
        next_cycle();
        n_total++;
        if (o_cdb_valid !== 1'b0) $display("FAIL single_cdb_clear: got v=%b want 0", o_cdb_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                   4'b0100, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        logic       exp_v [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_s [11] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        do_reset();
        set_rdy(4'b1111);
        for (int t = 0; t < 11; t++) begin
            #1;
            n_total++;
            if (iss !== exp_g[t]) $display("FAIL rr_grant t%0d: got %b want %b", t, iss, exp_g[t]);
            else n_pass++;
            n_total++;
            if (o_cdb_valid !== exp_v[t] || (exp_v[t] && o_cdb_sel !== exp_s[t]))
                $display("FAIL rr_cdb t%0d: got v=%b s=%0d want v=%b s=%0d",
                         t, o_cdb_valid, o_cdb_sel, exp_v[t], exp_s[t]);
            else n_pass++;
            next_cycle();
        end
        set_rdy(4'b0000);
    endtask

    task automatic test_mem_blocked;
        do_reset();
        rdy_mult = 1'b1;
        #1;
        n_total++;
        if (iss !== 4'b0100) $display("FAIL blk_mult_issue: got %b want 0100", iss);
        else n_pass++;
        next_cycle();
        rdy_mult = 1'b0;
        next_cycle();
        rdy_mem = 1'b1;
        #1;
        n_total++;
        if (iss !== 4'b0000) $display("FAIL blk_mem_t2: got %b want 0000", iss);
        else n_pass++;
        next_cycle();
        n_total++;
        if (iss !== 4'b0010) $display("FAIL blk_mem_t3: got %b want 0010", iss);
        else n_pass++;
        next_cycle();
        rdy_mem = 1'b0;
        #1;
        n_total++;
        if (o_cdb_valid !== 1'b1 || o_cdb_sel !== 2'd2)
            $display("FAIL blk_cdb_t4: got v=%b s=%0d want v=1 s=2", o_cdb_valid, o_cdb_sel);
        else n_pass++;
        next_cycle();
        n_total++;
        if (o_cdb_valid !== 1'b1 || o_cdb_sel !== 2'd1)
            $display("FAIL blk_cdb_t5: got v=%b s=%0d want v=1 s=1", o_cdb_valid, o_cdb_sel);
        else n_pass++;
        next_cycle();
        n_total++;
        if (o_cdb_valid !== 1'b0) $display("FAIL blk_cdb_t6: got v=%b want 0", o_cdb_valid);
        else n_pass++;
    endtask

    task automatic test_div_lockout;
        do_reset();
        rdy_div = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            #1;
            n_total++;
            if (issue_div !== (t % 6 == 0))
                $display("FAIL div_issue t%0d: got %b want %b", t, issue_div, (t % 6 == 0));
            else n_pass++;
            n_total++;
            if (o_cdb_valid !== (t == 6 || t == 12) || ((t == 6 || t == 12) && o_cdb_sel !== 2'd3))
                $display("FAIL div_cdb t%0d: got v=%b s=%0d want v=%b s=3",
                         t, o_cdb_valid, o_cdb_sel, (t == 6 || t == 12));
            else n_pass++;
            next_cycle();
        end
        rdy_div = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        rdy_mult = 1'b1;
        #1;
        n_total++;
        if (iss !== 4'b0100) $display("FAIL flush_mult_issue: got %b want 0100", iss);
        else n_pass++;
        next_cycle();
        rdy_mult = 1'b0;
        next_cycle();
        flush = 1'b1;
        set_rdy(4'b1111);
        #1;
        n_total++;
        if (iss !== 4'b0000) $display("FAIL flush_issue: got %b want 0000", iss);
        else n_pass++;
        next_cycle();
        flush = 1'b0;
        #1;
        n_total++;
        if (iss !== 4'b1000) $display("FAIL flush_ptr_kept: got %b want 1000", iss);
        else n_pass++;
        next_cycle();
        set_rdy(4'b0000);
        #1;
        n_total++;
        if (o_cdb_valid !== 1'b0) $display("FAIL flush_cdb_t4: got v=%b want 0", o_cdb_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        rdy_div = 1'b1;
        #1;
        n_total++;
        if (issue_div !== 1'b1) $display("FAIL rstmid_div_t0: got %b want 1", issue_div);
        else n_pass++;
        next_cycle();
        rdy_div = 1'b0;
        i_rst_n = 1'b0;
        #1;
        n_total++;
        if (iss !== 4'b0000) $display("FAIL rstmid_issue_t1: got %b want 0000", iss);
        else n_pass++;
        next_cycle();
        i_rst_n = 1'b1;
        rdy_div = 1'b1;
        #1;
        n_total++;
        if (issue_div !== 1'b1) $display("FAIL rstmid_div_t2: got %b want 1", issue_div);
        else n_pass++;
        for (int t = 2; t <= 6; t++) begin
            n_total++;
            if (o_cdb_valid !== 1'b0) $display("FAIL rstmid_cdb t%0d: got v=%b want 0", t, o_cdb_valid);
            else n_pass++;
            next_cycle();
            rdy_div = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_int();
        test_round_robin();
        test_mem_blocked();
        test_div_lockout();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter LAT_INT, default 1: integer-unit latency in cycles, issue to CDB.
REQ-002 SHALL have parameter LAT_MEM, default 2: load/store-unit latency in cycles.
REQ-003 SHALL have parameter LAT_MULT, default 4: pipelined multiplier latency in cycles.
REQ-004 SHALL have parameter LAT_DIV, default 6: non-pipelined divider latency in cycles.
REQ-005 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port flush  input  1  pipeline flush; kills in-flight bookings.
REQ-008 SHALL have ports rdy_int, rdy_mem, rdy_mult, rdy_div  input  1 each  reservation-station issue_queue_rdy.
REQ-009 SHALL have ports issue_int, issue_mem, issue_mult, issue_div  output  1 each  grant; drives the station's issue_completed.
REQ-010 SHALL have port o_cdb_valid  output  1  a booked result owns the CDB this cycle.
REQ-011 SHALL have port o_cdb_sel  output  2  owning unit id (0 INT, 1 MEM, 2 MULT, 3 DIV).

Function
REQ-012 SHALL assert at most one issue_* per cycle; issue_* are combinational from rdy_* and current state.
REQ-013 SHALL keep booking vector res[MAX_LAT:0], MAX_LAT = max of the four latencies; res[k]=1 means the CDB is owned k cycles from now.
REQ-014 Unit X SHALL be eligible when rdy_X=1, res[LAT_X]=0, flush=0, and (X=DIV only) div_cnt=0.
REQ-015 Among eligible units SHALL grant round-robin starting at pointer rr_ptr (2 bits); on a grant rr_ptr <= granted id + 1 (mod 4); no grant leaves rr_ptr unchanged.
REQ-016 Each edge SHALL update res <= (res | onehot(LAT_g)) >> 1 (onehot term zero if no grant), and shift a parallel 2-bit owner array identically, loading owner[LAT_g] <= g.
REQ-017 o_cdb_valid/o_cdb_sel SHALL be res[0]/owner[0]; a unit granted at cycle t SHALL appear on the outputs at cycle t+LAT_X.
REQ-018 On a div grant SHALL load div_cnt <= LAT_DIV-1, else decrement while nonzero; next div grant earliest at t+LAT_DIV.
REQ-019 Multiplier SHALL accept back-to-back grants subject only to REQ-014 booking checks.
REQ-020 flush SHALL force all issue_* low that cycle and on the edge clear res, owner, div_cnt; rr_ptr is kept.
REQ-021 Equal latencies conflicting at res[L] SHALL be resolved by REQ-014: only one unit books slot L.

Reset
REQ-022 While i_rst_n=0 at an edge: res, owner, div_cnt, rr_ptr SHALL clear to 0; issue_* SHALL be 0 combinationally while i_rst_n=0; o_cdb_valid=0, o_cdb_sel=0 after the edge.
REQ-023 Reset mid-operation SHALL discard all bookings; no CDB output afterwards until a new grant.

Structure
REQ-024 Unit-id enum (INT/MEM/MULT/DIV) and default latency constants SHALL live in the shared package.
REQ-025 Round-robin selection SHALL be a sub-module rr_arbiter4 (4 requests, 2-bit pointer, one-hot grant).

Verification
REQ-026 Reset, then rdy_int=1 only at t0 -> issue_int at t0; o_cdb_valid=1, o_cdb_sel=0 at t0+1.
REQ-027 All rdy high constantly from rr_ptr=0 -> grant order INT, MEM, MULT, DIV, then INT; div not regranted before 6 cycles; never two CDB owners per cycle.
REQ-028 rdy_mult issued t0, rdy_mem only at t0+2 -> MEM blocked (slot 2 = t0+4 owned); granted t0+3; CDB: MULT t0+4, MEM t0+5.
REQ-029 rdy_div held high -> issue_div at t0 and t0+6 only; o_cdb_sel=3 at t0+6 and t0+12.
REQ-030 MULT granted t0, flush at t0+2 -> no issue_* at t0+2; o_cdb_valid stays 0 at t0+4.
REQ-031 i_rst_n=0 at t0+1 after DIV grant at t0 -> div_cnt=0, o_cdb_valid=0 through t0+6; rdy_div at t0+2 granted.
